// File: rtl/fabric_port_in_tx.sv
// fabric_port_in_tx
//   Transmit-side fabric port. Accepts a whole packet (1..4 flits) from user
//   RTL and serializes it onto the NoC, one flit per cycle. Every flit of a
//   packet uses the single VC that was chosen when the packet was accepted.
//   Downstream buffer space is tracked with one credit counter per VC.
//
// Ports
//   clk_noc         in   NoC clock; all state changes on the rising edge
//   rst             in   asynchronous, active-high reset
//   rtl_packet_in   in   4 flit slots; only the payload bits of each slot are used
//   rtl_len_in      in   packet length minus one
//   rtl_vc_in       in   requested VC (ignored with FPI_VC_AUTO_EN)
//   rtl_valid_in    in   packet present
//   rtl_ready_out   out  packet can be accepted this cycle
//   noc_flit_out    out  registered flit to the router, all-zero when idle/stalled
//   noc_credits_in  in   one-cycle credit-return pulse per VC
//
// Configuration
//   FPI_VC_AUTO_EN  when defined, the VC is picked round-robin among VCs with
//                   credit, and no packet is accepted while every VC is empty.
//
// FSM states
//   state | meaning
//   IDLE  | waiting for a packet from user RTL
//   SEND  | emitting flits of the captured packet while credit allows

module fabric_port_in_tx #(
  parameter int WIDTH_NOC        = 8,
  parameter int NUM_VC           = 2,
  parameter int DEPTH_PER_VC     = 8,
  parameter int VC_ADDRESS_WIDTH = $clog2(NUM_VC),
  parameter int CREDIT_WIDTH     = $clog2(DEPTH_PER_VC + 1)
) (
  input  logic                        clk_noc,
  input  logic                        rst,
  input  logic [4*WIDTH_NOC-1:0]      rtl_packet_in,
  input  logic [1:0]                  rtl_len_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] rtl_vc_in,
  input  logic                        rtl_valid_in,
  output logic                        rtl_ready_out,
  output logic [WIDTH_NOC-1:0]        noc_flit_out,
  input  logic [NUM_VC-1:0]           noc_credits_in
);

  localparam int PW = WIDTH_NOC - 3 - VC_ADDRESS_WIDTH;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;
  localparam logic [CREDIT_WIDTH-1:0] CR_MAX = CREDIT_WIDTH'(DEPTH_PER_VC);

  logic [0:0]                  r_state;
  logic [PW-1:0]               r_payload [4];
  logic [1:0]                  r_len;
  logic [1:0]                  r_idx;
  logic [VC_ADDRESS_WIDTH-1:0] r_vc;
  logic [CREDIT_WIDTH-1:0]     r_credit [NUM_VC];
  logic [WIDTH_NOC-1:0]        r_flit;

  logic                        w_emit;
  logic                        w_last;
  logic                        w_accept;
  logic                        w_can_accept;
  logic [VC_ADDRESS_WIDTH-1:0] w_vc_sel;
  logic [NUM_VC-1:0]           w_dec;
  logic [NUM_VC-1:0]           w_inc;
  logic                        w_unused_hdr;

  // Header bits of the incoming slots are regenerated here, never forwarded.
  always_comb begin
    w_unused_hdr = 1'b0;
    for (int k = 0; k < 4; k++)
      w_unused_hdr = w_unused_hdr ^ (^rtl_packet_in[k*WIDTH_NOC+PW +: WIDTH_NOC-PW]);
  end

`ifdef FPI_VC_AUTO_EN
  logic [VC_ADDRESS_WIDTH-1:0] r_last_vc;
  logic [VC_ADDRESS_WIDTH-1:0] w_auto_vc;
  logic                        w_auto_found;
  logic                        w_unused_vc;

  assign w_unused_vc = ^rtl_vc_in;

  // Round-robin search starting just after the last VC used.
  always_comb begin
    w_auto_found = 1'b0;
    w_auto_vc    = '0;
    for (int i = 1; i <= NUM_VC; i++) begin
      if (!w_auto_found && (r_credit[(int'(r_last_vc) + i) % NUM_VC] != '0)) begin
        w_auto_found = 1'b1;
        w_auto_vc    = VC_ADDRESS_WIDTH'((int'(r_last_vc) + i) % NUM_VC);
      end
    end
  end

  assign w_vc_sel     = w_auto_vc;
  assign w_can_accept = w_auto_found;

  always_ff @(posedge clk_noc or posedge rst) begin
    if (rst)
      r_last_vc <= VC_ADDRESS_WIDTH'(NUM_VC - 1);
    else if (w_accept)
      r_last_vc <= w_auto_vc;
  end
`else
  assign w_vc_sel     = rtl_vc_in;
  assign w_can_accept = 1'b1;
`endif

  assign rtl_ready_out = (r_state == S_IDLE) && !rst && w_can_accept;
  assign w_accept      = rtl_valid_in && rtl_ready_out;
  assign w_emit        = (r_state == S_SEND) && (r_credit[r_vc] != '0);
  assign w_last        = (r_idx == r_len);
  assign noc_flit_out  = r_flit;

  always_ff @(posedge clk_noc or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_vc    <= '0;
      r_flit  <= '0;
      for (int k = 0; k < 4; k++)
        r_payload[k] <= '0;
    end else begin
      r_flit <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            for (int k = 0; k < 4; k++)
              r_payload[k] <= rtl_packet_in[k*WIDTH_NOC +: PW];
            r_len   <= rtl_len_in;
            r_vc    <= w_vc_sel;
            r_idx   <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_emit) begin
            r_flit <= {1'b1, (r_idx == 2'd0), w_last, r_vc, r_payload[r_idx]};
            r_idx  <= r_idx + 2'd1;
            if (w_last)
              r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A returned credit coinciding with an emit on the same VC cancels out,
  // even when the counter sits at its maximum.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_dec[v] = w_emit && (int'(r_vc) == v);
      w_inc[v] = noc_credits_in[v] && ((r_credit[v] != CR_MAX) || w_dec[v]);
    end
  end

  always_ff @(posedge clk_noc or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++)
        r_credit[v] <= CR_MAX;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_inc[v] && !w_dec[v])
          r_credit[v] <= r_credit[v] + CREDIT_WIDTH'(1);
        else if (w_dec[v] && !w_inc[v])
          r_credit[v] <= r_credit[v] - CREDIT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fabric_port_in_tx.sv
module tb_fabric_port_in_tx;

  logic        clk_noc = 1'b0;
  logic        rst;
  logic [31:0] rtl_packet_in;
  logic [1:0]  rtl_len_in;
  logic [0:0]  rtl_vc_in;
  logic        rtl_valid_in;
  logic        rtl_ready_out;
  logic [7:0]  noc_flit_out;
  logic [1:0]  noc_credits_in;

  int n_chk = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int acc_limit = 1000000;

`ifdef FPI_VC_AUTO_EN
  localparam logic [7:0] VCB = 8'h10;
`else
  localparam logic [7:0] VCB = 8'h00;
`endif

  always #5 clk_noc = ~clk_noc;

  fabric_port_in_tx dut (
    .clk_noc        (clk_noc),
    .rst            (rst),
    .rtl_packet_in  (rtl_packet_in),
    .rtl_len_in     (rtl_len_in),
    .rtl_vc_in      (rtl_vc_in),
    .rtl_valid_in   (rtl_valid_in),
    .rtl_ready_out  (rtl_ready_out),
    .noc_flit_out   (noc_flit_out),
    .noc_credits_in (noc_credits_in)
  );

  typedef struct {
    logic       valid;
    logic [1:0] len;
    logic [0:0] vc;
    logic [31:0] pkt;
    logic [1:0] cred;
    logic [7:0] exp_flit;
    logic       exp_rdy;
    logic [3:0] exp_cr0;
    logic [3:0] exp_cr1;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge; counts packets accepted at that edge.
  task automatic tick();
    logic acc;
    acc = rtl_valid_in && rtl_ready_out;
    @(posedge clk_noc);
    #1;
    if (acc) begin
      acc_cnt++;
      if (acc_cnt >= acc_limit) rtl_valid_in = 1'b0;
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq4 [4];
    logic [7:0] phase1 [14];
    seq4 = '{8'hC0, 8'h81, 8'h82, 8'hA3};
    phase1 = '{8'h00, 8'hC0, 8'h81, 8'h82, 8'hA3, 8'h00, 8'hC0, 8'h81, 8'h82, 8'hA3,
               8'h00, 8'h00, 8'h00, 8'h00};

    //           valid len vc pkt                         cred  flit   rdy cr0 cr1
    vecs[0]  = '{1'b1, 2'd3, 1'b0, pk(8'h00,8'h01,8'h02,8'h03), 2'b00, 8'h00, 1'b0, 4'd8, 4'd8};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b00, 8'hC0, 1'b0, 4'd7, 4'd8};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b00, 8'h81, 1'b0, 4'd6, 4'd8};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b00, 8'h82, 1'b0, 4'd5, 4'd8};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b00, 8'hA3, 1'b1, 4'd4, 4'd8};
    vecs[5]  = '{1'b1, 2'd0, 1'b1, pk(8'hE5,8'h00,8'h00,8'h00), 2'b00, 8'h00, 1'b0, 4'd4, 4'd8};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b00, 8'hF5, 1'b1, 4'd4, 4'd7};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b11, 8'h00, 1'b1, 4'd5, 4'd8};
    vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b10, 8'h00, 1'b1, 4'd5, 4'd8};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, pk(8'h07,8'h08,8'h00,8'h00), 2'b00, 8'h00, 1'b0, 4'd5, 4'd8};
    vecs[10] = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b01, 8'hC7, 1'b0, 4'd5, 4'd8};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b00, 8'hA8, 1'b1, 4'd4, 4'd8};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b01, 8'h00, 1'b1, 4'd5, 4'd8};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b01, 8'h00, 1'b1, 4'd6, 4'd8};
    vecs[14] = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b01, 8'h00, 1'b1, 4'd7, 4'd8};
    vecs[15] = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b01, 8'h00, 1'b1, 4'd8, 4'd8};
    vecs[16] = '{1'b0, 2'd0, 1'b0, 32'h0,                       2'b01, 8'h00, 1'b1, 4'd8, 4'd8};

    rst = 1'b1;
    rtl_packet_in = '0; rtl_len_in = '0; rtl_vc_in = '0;
    rtl_valid_in = 1'b0; noc_credits_in = '0;
    #2;
    chk("reset_flit", noc_flit_out, 8'h00);
    chk("reset_ready", rtl_ready_out, 1'b0);
    chk("reset_cr0", dut.r_credit[0], 4'd8);
    chk("reset_cr1", dut.r_credit[1], 4'd8);
    @(posedge clk_noc); #1;
    @(posedge clk_noc); #1;
    rst = 1'b0;
    #1;
    chk("post_reset_ready", rtl_ready_out, 1'b1);

    // Table-driven vectors
    for (int i = 0; i < 17; i++) begin
      rtl_valid_in   = vecs[i].valid;
      rtl_len_in     = vecs[i].len;
      rtl_vc_in      = vecs[i].vc;
      rtl_packet_in  = vecs[i].pkt;
      noc_credits_in = vecs[i].cred;
      tick();
      chk($sformatf("vec%0d_flit", i), noc_flit_out, vecs[i].exp_flit);
      chk($sformatf("vec%0d_ready", i), rtl_ready_out, vecs[i].exp_rdy);
      chk($sformatf("vec%0d_cr0", i), dut.r_credit[0], vecs[i].exp_cr0);
      chk($sformatf("vec%0d_cr1", i), dut.r_credit[1], vecs[i].exp_cr1);
    end
    rtl_valid_in = 1'b0; noc_credits_in = '0;

`ifndef FPI_VC_AUTO_EN
    // Ten back-to-back 4-flit packets on VC0 with no credit return
    acc_cnt = 0; acc_limit = 10;
    rtl_len_in = 2'd3; rtl_vc_in = 1'b0;
    rtl_packet_in = pk(8'h00, 8'h01, 8'h02, 8'h03);
    rtl_valid_in = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk($sformatf("b2b_flit%0d", i), noc_flit_out, phase1[i]);
    end
    chk("stall_ready", rtl_ready_out, 1'b0);
    chk("stall_accepts", acc_cnt, 3);
    chk("stall_cr0", dut.r_credit[0], 4'd0);
    for (int f = 0; f < 32; f++) begin
      noc_credits_in = 2'b01;
      tick();
      chk($sformatf("pulse%0d_edge", f), noc_flit_out, 8'h00);
      noc_credits_in = 2'b00;
      tick();
      chk($sformatf("pulse%0d_release", f), noc_flit_out, seq4[f % 4]);
      tick();
      chk($sformatf("pulse%0d_after", f), noc_flit_out, 8'h00);
    end
    chk("b2b_accepts", acc_cnt, 10);
    chk("b2b_ready", rtl_ready_out, 1'b1);
    chk("b2b_cr0", dut.r_credit[0], 4'd0);
    acc_limit = 1000000;
    rtl_valid_in = 1'b0;
    noc_credits_in = 2'b01;
    for (int i = 0; i < 8; i++) tick();
    noc_credits_in = 2'b00;
    chk("refill_cr0", dut.r_credit[0], 4'd8);
`endif

    // Reset in the middle of a packet
    rtl_len_in = 2'd3; rtl_vc_in = 1'b0;
    rtl_packet_in = pk(8'h00, 8'h01, 8'h02, 8'h03);
    rtl_valid_in = 1'b1;
    tick();
    rtl_valid_in = 1'b0;
    tick(); chk("mid_f0", noc_flit_out, 8'hC0 | VCB);
    tick(); chk("mid_f1", noc_flit_out, 8'h81 | VCB);
    tick(); chk("mid_f2", noc_flit_out, 8'h82 | VCB);
    rst = 1'b1;
    #1;
    chk("mid_rst_flit", noc_flit_out, 8'h00);
    chk("mid_rst_ready", rtl_ready_out, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("mid_rel_cr0", dut.r_credit[0], 4'd8);
    chk("mid_rel_cr1", dut.r_credit[1], 4'd8);
    chk("mid_rel_ready", rtl_ready_out, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid_no_tail%0d", i), noc_flit_out, 8'h00);
    end

`ifdef FPI_VC_AUTO_EN
    // Round-robin VC selection: drain VC0 while VC1 is kept topped up
    acc_limit = 1000000;
    rtl_len_in = 2'd3; rtl_vc_in = 1'b0;
    rtl_packet_in = pk(8'h00, 8'h01, 8'h02, 8'h03);
    noc_credits_in = 2'b10;
    rtl_valid_in = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    noc_credits_in = 2'b00;
    chk("auto_cr0", dut.r_credit[0], 4'd0);
    chk("auto_cr1", dut.r_credit[1], 4'd8);
    tick();
    tick(); chk("auto_head_vc1", noc_flit_out, 8'hD0);
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    chk("auto_cr1_empty", dut.r_credit[1], 4'd0);
    chk("auto_ready_low", rtl_ready_out, 1'b0);
    tick(); tick();
    chk("auto_ready_low2", rtl_ready_out, 1'b0);
    chk("auto_idle_flit", noc_flit_out, 8'h00);
    rtl_valid_in = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fabric_port_in_tx.md
# fabric_port_in_tx

Transmit-side fabric port: accepts whole packets from the FPGA fabric (RTL side) and serializes them into NoC flits on a single virtual channel per packet. Flow control is credit-based, and the block mirrors the receiving fabric port's flit format. One per-VC credit counter tracks free downstream buffer slots, and the counters are replenished by credit pulses from the receiver. The block sits between user RTL and a NoC router input, in the same clock domain as the NoC.

## Interface
- WIDTH_NOC, 8, flit width in bits
- NUM_VC, 2, number of virtual channels
- DEPTH_PER_VC, 8, downstream buffer depth per VC; initial credit count
- VC_ADDRESS_WIDTH, $clog2(NUM_VC), VC field width (derived)
- CREDIT_WIDTH, $clog2(DEPTH_PER_VC+1), credit counter width (derived)

- clk_noc  in  1  the only clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- rtl_packet_in  in  4*WIDTH_NOC  flit k is slice [k*WIDTH_NOC +: WIDTH_NOC]; only its payload bits are used
- rtl_len_in  in  2  packet length minus one (0 = 1 flit … 3 = 4 flits)
- rtl_vc_in  in  VC_ADDRESS_WIDTH  requested VC (ignored when FPI_VC_AUTO_EN is defined)
- rtl_valid_in  in  1  packet present
- rtl_ready_out  out  1  block can accept a packet
- noc_flit_out  out  WIDTH_NOC  registered flit to router
- noc_credits_in  in  NUM_VC  one-cycle credit-return pulse per VC

## Operation
- Flit fields:
  - VALID = bit WIDTH_NOC-1.
  - HEAD = bit WIDTH_NOC-2.
  - TAIL = bit WIDTH_NOC-3.
  - VC = [WIDTH_NOC-4 -: VC_ADDRESS_WIDTH].
  - Payload = [WIDTH_NOC-4-VC_ADDRESS_WIDTH : 0], copied from the same bits of the RTL slice.
- FSM has two states, IDLE and SEND.
  - rtl_ready_out = (state==IDLE) & ~rst.
- IDLE:
  - When rtl_valid_in & rtl_ready_out, capture the packet, the length and the VC into internal registers.
  - Clear the flit index to 0 and go to SEND.
- SEND, each cycle:
  - If credit[vc] > 0, emit flit[index] with VALID=1, HEAD=(index==0), TAIL=(index==len), VC=captured vc.
  - On emit, decrement credit[vc] and increment the index.
  - If index==len on emit, go to IDLE.
  - If credit[vc]==0, emit noc_flit_out = 0 (stall); the packet stays in SEND.
- Wormhole rule: all flits of a packet use the VC captured at acceptance.
  - A 1-flit packet has HEAD=TAIL=1.
- Credit counters:
  - Reset to DEPTH_PER_VC.
  - −1 on emit on that VC; +1 on noc_credits_in[v].
  - Simultaneous emit and credit on the same VC: the counter is unchanged.
  - Never exceeds DEPTH_PER_VC; a credit pulse arriving at DEPTH_PER_VC is ignored.
  - Never decrements below 0.
- Whenever no flit is emitted, noc_flit_out is all-zero.

## Timing
- Reset (asynchronous):
  - noc_flit_out=0, state=IDLE, index=0.
  - Both credit counters = DEPTH_PER_VC.
  - rtl_ready_out=0 while rst is high.
- Latency: a packet accepted at posedge k puts its head flit on noc_flit_out after posedge k+1, provided credit is available.
- Throughput: one flit per cycle while credits allow.
  - A packet of len+1 flits occupies len+1 SEND cycles plus one IDLE cycle.
  - Back-to-back 4-flit packets therefore give 4 valid flits followed by 1 bubble.
- The emit decision uses the registered credit count. A credit pulse at posedge k makes a stalled flit go out after posedge k+1.
- rst asserted mid-packet aborts the packet; no partial tail is sent after reset.

## Configuration
- FPI_VC_AUTO_EN defined:
  - At acceptance the VC is chosen by round-robin among VCs with credit > 0, starting after the VC used last.
  - If no VC has credit, rtl_ready_out stays low.
  - rtl_vc_in is ignored.
- FPI_VC_AUTO_EN undefined:
  - The VC is rtl_vc_in.
  - Acceptance does not depend on credits.

## Test plan
- Reset, then a single 4-flit packet on VC0 with payloads 0,1,2,3:
  - Flits 0xC0, 0x81, 0x82, 0xA3 appear on 4 consecutive cycles.
  - credit[0]=4 afterwards.
- 1-flit packet with rtl_len_in=0, VC1, payload 5 → single flit 0xF5 (HEAD and TAIL both set), credit[1]=7.
- Ten back-to-back 4-flit packets on VC0 with no credit return:
  - The first 8 flits are emitted, then noc_flit_out=0 and the FSM stalls in SEND.
  - Each later single credit pulse releases exactly one flit after the next edge.
- Credit pulse and emit in the same cycle on VC0 → credit[0] unchanged.
  - A credit pulse at a count of 8 leaves the count at 8.
- rst asserted during flit 2 of a packet:
  - noc_flit_out=0 immediately.
  - After release, credits are 8/8 and rtl_ready_out=1; no tail flit is emitted.
- With FPI_VC_AUTO_EN: credit[0]=0, credit[1]=8 → the next packet goes on VC1. With both VCs at 0 → rtl_ready_out=0.
